// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle logic/arith/shift ops plus iterative mul/div into HI/LO.
// Optional: define ALU_SEQ_OVF_EN to add the ovf output (signed overflow of ADD/SUB).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             divz
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Per-operation context held across CALC/FIX for mul/div.
  typedef struct packed {
    logic div;
    logic neg_lo;
    logic neg_hi;
  } md_req_t;

  state_t           state, state_d;
  md_req_t          md_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, mq, mcand;

  logic             accept, is_md, is_div, is_sgn, div0;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] add_r, sub_r, sc_res;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] lo_fix, hi_fix;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign accept = start && ready;

  // ops 12..15: bit1 selects divide, bit0 selects signed
  assign is_md  = op[3] & op[2];
  assign is_div = is_md & op[1];
  assign is_sgn = is_md & op[0];
  assign div0   = is_div && (b == '0);
  assign mag_a  = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (is_sgn && b[WIDTH-1]) ? -b : b;

  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    sc_res = '0;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD:  sc_res = add_r;
      OP_SLL:  sc_res = b << shamt;
      OP_SRL:  sc_res = b >> shamt;
      OP_LUI:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SUB:  sc_res = sub_r;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  sc_res = ~(a | b);
      OP_XOR:  sc_res = a ^ b;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  sc_res = $unsigned($signed(b) >>> shamt);
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic sc_ovf;
  always_comb begin
    sc_ovf = 1'b0;
    if (op == OP_ADD) sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    if (op == OP_SUB) sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  // One iteration per CALC cycle: shift-add multiply on {acc,mq}, restoring divide with
  // acc as partial remainder and mq as dividend shifting out / quotient shifting in.
  assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign div_sh   = {acc, mq[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mcand};
  assign prod     = {acc, mq};

  always_comb begin
    lo_fix = mq;
    hi_fix = acc;
    if (md_q.div) begin
      lo_fix = md_q.neg_lo ? -mq  : mq;
      hi_fix = md_q.neg_hi ? -acc : acc;
    end else begin
      {hi_fix, lo_fix} = md_q.neg_lo ? -prod : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: state_d = accept ? ((is_md && !div0) ? CALC : DONE) : IDLE;
      CALC:       if (cnt == '0) state_d = FIX;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      divz   <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      md_q   <= '0;
`ifdef ALU_SEQ_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (accept) begin
          divz <= div0;
          if (div0) begin
            result <= '1;
            hi     <= a;
            zero   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
          end else if (is_md) begin
            acc         <= '0;
            mq          <= mag_a;
            mcand       <= mag_b;
            cnt         <= SHW'(WIDTH-1);
            md_q.div    <= is_div;
            md_q.neg_lo <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            // remainder follows the dividend; product uses the same flag as LO
            md_q.neg_hi <= is_sgn & (is_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
          end else begin
            result <= sc_res;
            hi     <= '0;
            zero   <= (sc_res == '0);
`ifdef ALU_SEQ_OVF_EN
            ovf    <= sc_ovf;
`endif
          end
        end
        CALC: begin
          cnt <= cnt - SHW'(1);
          if (md_q.div) begin
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_sh[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc, mq} <= {mul_sum, mq[WIDTH-1:1]};
          end
        end
        FIX: begin
          result <= lo_fix;
          hi     <= hi_fix;
          zero   <= (lo_fix == '0);
`ifdef ALU_SEQ_OVF_EN
          ovf    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + randomized checks of alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  op;
  logic [31:0] a, b, result, hi;
  logic [4:0]  shamt;
  logic        ready, busy, done, zero, divz;
`ifdef ALU_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .ready(ready), .busy(busy), .done(done), .result(result), .hi(hi),
    .zero(zero), .divz(divz)
`ifdef ALU_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic on the operand values.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, y, input logic [4:0] s,
                                output logic [31:0] r, output logic [31:0] h,
                                output logic dz, output logic ov);
    longint sx, sy, p;
    logic [63:0] u;
    logic signed [31:0] ty;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ty = $signed(y);
    r = '0; h = '0; dz = 1'b0; ov = 1'b0;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  begin r = x + y; p = sx + sy; ov = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      4'd3:  r = y << s;
      4'd4:  r = y >> s;
      4'd5:  r = {y[15:0], 16'h0000};
      4'd6:  begin r = x - y; p = sx - sy; ov = (p > 64'sd2147483647) || (p < -64'sd2147483648); end
      4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  r = ~(x | y);
      4'd9:  r = x ^ y;
      4'd10: r = (x < y) ? 32'd1 : 32'd0;
      4'd11: r = $unsigned(ty >>> s);
      4'd12: begin u = {32'h0, x} * {32'h0, y}; r = u[31:0]; h = u[63:32]; end
      4'd13: begin p = sx * sy; r = p[31:0]; h = p[63:32]; end
      4'd14: if (y == 0) begin r = '1; h = x; dz = 1'b1; end
             else begin r = x / y; h = x % y; end
      default: if (y == 0) begin r = '1; h = x; dz = 1'b1; end
               else begin p = sx / sy; r = p[31:0]; p = sx % sy; h = p[31:0]; end
    endcase
  endfunction

  // Issue one op from a negedge with ready=1, wait for done, check latency and outputs.
  task automatic run(input logic [3:0] o, input logic [31:0] x, y, input logic [4:0] s, input bit poke);
    logic [31:0] er, eh;
    logic edz, eov;
    int lat, exp_lat;
    bit busy_ok;
    model(o, x, y, s, er, eh, edz, eov);
    exp_lat = (o >= 4'd12 && !(o >= 4'd14 && y == 0)) ? 34 : 1;
    start = 1'b1; op = o; a = x; b = y; shamt = s;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = (poke && lat == 5);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check($sformatf("op%0d latency", o), 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check($sformatf("op%0d busy", o), {63'd0, busy_ok}, 64'd1);
    check($sformatf("op%0d result", o), {32'd0, result}, {32'd0, er});
    check($sformatf("op%0d hi", o), {32'd0, hi}, {32'd0, eh});
    check($sformatf("op%0d zero", o), {63'd0, zero}, {63'd0, (er == 0)});
    check($sformatf("op%0d divz", o), {63'd0, divz}, {63'd0, edz});
`ifdef ALU_SEQ_OVF_EN
    check($sformatf("op%0d ovf", o), {63'd0, ovf}, {63'd0, eov});
`endif
    @(negedge clk);
    check($sformatf("op%0d done pulse", o), {62'd0, done, ready}, 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] x, y;
    logic [3:0]  o;
    int lat;
    bit quiet;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("reset outs", {result, hi}, 64'd0);
    check("reset flags", {59'd0, ready, busy, done, zero, divz}, {59'd0, 5'b10000});
    rst_n = 1'b1;
    @(negedge clk);

    run(4'd2, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0);
    check("add const", {32'd0, result}, 64'h80000000);
    run(4'd7, 32'h80000000, 32'h1, 5'd0, 1'b0);
    check("slt const", {32'd0, result}, 64'd1);
    run(4'd10, 32'h80000000, 32'h1, 5'd0, 1'b0);
    run(4'd6, 32'd5, 32'd5, 5'd0, 1'b0);
    check("sub zero", {63'd0, zero}, 64'd1);
    run(4'd13, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b1);
    check("mult const", {hi, result}, 64'hFFFFFFFF_FFFFFFEB);
    run(4'd15, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    check("div const", {hi, result}, 64'hFFFFFFFF_FFFFFFFD);
    run(4'd14, 32'd100, 32'd0, 5'd0, 1'b0);
    check("divz const", {31'd0, divz, result}, 64'h1_FFFFFFFF);
    run(4'd15, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);

    // reset in the middle of CALC
    start = 1'b1; op = 4'd12; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outs", {result, hi}, 64'd0);
    check("midreset flags", {59'd0, ready, busy, done, zero, divz}, {59'd0, 5'b10000});
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    check("midreset no done", {63'd0, quiet}, 64'd1);
    run(4'd12, 32'd123456, 32'd789, 5'd0, 1'b0);

    // back-to-back: start held through DONE with the next op presented
    start = 1'b1; op = 4'd14; a = 32'd100; b = 32'd7; shamt = '0;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    check("b2b latency", 64'(lat), 64'd34);
    check("b2b divu", {hi, result}, {32'd2, 32'd14});
    op = 4'd11; a = $urandom; b = 32'h80000000; shamt = 5'd4;
    @(negedge clk);
    start = 1'b0;
    check("b2b sra done", {63'd0, done}, 64'd1);
    check("b2b sra", {hi, result}, 64'h00000000_F8000000);
    @(negedge clk);
    check("b2b idle", {62'd0, done, ready}, 64'd1);

    repeat (60) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 5) == 0) y = x;
      run(o, x, y, 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
